// File: rtl/hood_mode_sequencer.sv
// Central mode FSM of the exhaust hood: turns button pulses and the third-mode
// return toggle into the registered mode code, with the clean countdown and menu timeout.
module hood_mode_sequencer #(
  parameter int CNT_WIDTH    = 32,
  parameter int CLEAN_TIME   = 100,
  parameter int MENU_TIMEOUT = 50
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 menu_signal,
  input  logic                 first_req,
  input  logic                 second_req,
  input  logic                 third_req,
  input  logic                 clean_req,
  input  logic                 third_timeout_toggle,
  output logic [2:0]           current_mode,
  output logic                 menu_active,
  output logic                 third_used,
  output logic [CNT_WIDTH-1:0] clean_remaining,
  output logic                 clean_done,
  output logic                 mode_changed
);

  // state    | meaning
  // STANDBY  | hood off, waiting for the menu button
  // MENU     | menu open, waiting for a gear/clean choice or timeout
  // FIRST    | fan gear 1
  // SECOND   | fan gear 2
  // THIRD    | fan gear 3, left by menu or the timeout toggle
  // CLEAN    | self-clean countdown, not interruptible

  localparam logic [2:0] MODE_STANDBY = 3'd0;

  localparam int CLEAN_EFF = (CLEAN_TIME < 1) ? 1 : CLEAN_TIME;
  localparam int MENU_EFF  = (MENU_TIMEOUT < 1) ? 1 : MENU_TIMEOUT;

  localparam logic [CNT_WIDTH-1:0] CLEAN_LOAD = CNT_WIDTH'(CLEAN_EFF);
  localparam logic [CNT_WIDTH-1:0] MENU_LIMIT = CNT_WIDTH'(MENU_EFF);
  localparam logic [CNT_WIDTH-1:0] MENU_LAST  = CNT_WIDTH'(MENU_EFF - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  // Encodings of the gear/clean states equal their reported mode codes.
  typedef enum logic [2:0] {
    ST_STANDBY = 3'd0,
    ST_FIRST   = 3'd1,
    ST_SECOND  = 3'd2,
    ST_THIRD   = 3'd3,
    ST_CLEAN   = 3'd4,
    ST_MENU    = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] menu_cnt_q, menu_cnt_d;
  logic [CNT_WIDTH-1:0] clean_q, clean_d;
  logic                 third_used_q, third_used_d;
  logic                 clean_done_q, clean_done_d;
  logic                 mode_changed_q;
  logic                 third_ok;

  assign third_ok = third_req && !third_used_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= ST_STANDBY;
      menu_cnt_q     <= '0;
      clean_q        <= '0;
      third_used_q   <= 1'b0;
      clean_done_q   <= 1'b0;
      mode_changed_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      menu_cnt_q     <= menu_cnt_d;
      clean_q        <= clean_d;
      third_used_q   <= third_used_d;
      clean_done_q   <= clean_done_d;
      mode_changed_q <= (state_d != state_q);
    end
  end

  always_comb begin
    state_d      = state_q;
    menu_cnt_d   = '0;
    clean_d      = clean_q;
    third_used_d = third_used_q;
    clean_done_d = 1'b0;

    unique case (state_q)
      ST_STANDBY: begin
        if (menu_signal) state_d = ST_MENU;
      end

      ST_MENU: begin
        if (menu_signal) begin
          state_d = ST_STANDBY;
        end else if (clean_req) begin
          state_d = ST_CLEAN;
          clean_d = CLEAN_LOAD;
        end else if (third_ok) begin
          state_d      = ST_THIRD;
          third_used_d = 1'b1;
        end else if (second_req) begin
          state_d = ST_SECOND;
        end else if (first_req) begin
          state_d = ST_FIRST;
        end else begin
          // Saturating count; the cycle that reaches the limit closes the menu.
          menu_cnt_d = (menu_cnt_q < MENU_LIMIT) ? menu_cnt_q + CNT_ONE : menu_cnt_q;
          if (menu_cnt_q >= MENU_LAST) state_d = ST_STANDBY;
        end
      end

      ST_FIRST: begin
        if (menu_signal) begin
          state_d = ST_STANDBY;
        end else if (second_req) begin
          state_d = ST_SECOND;
        end else if (third_ok) begin
          state_d      = ST_THIRD;
          third_used_d = 1'b1;
        end
      end

      ST_SECOND: begin
        if (menu_signal) begin
          state_d = ST_STANDBY;
        end else if (third_ok) begin
          state_d      = ST_THIRD;
          third_used_d = 1'b1;
        end else if (first_req) begin
          state_d = ST_FIRST;
        end
      end

      ST_THIRD: begin
        if (menu_signal) begin
          state_d = ST_STANDBY;
        end else if (third_timeout_toggle) begin
          state_d = ST_SECOND;
        end
      end

      ST_CLEAN: begin
        if (clean_q <= CNT_ONE) begin
          state_d      = ST_STANDBY;
          clean_d      = '0;
          clean_done_d = 1'b1;
        end else begin
          clean_d = clean_q - CNT_ONE;
        end
      end

      default: begin
        state_d = ST_STANDBY;
        clean_d = '0;
      end
    endcase
  end

  always_comb begin
    current_mode = (state_q == ST_MENU) ? MODE_STANDBY : 3'(state_q);
    menu_active  = (state_q == ST_MENU);
  end

  assign third_used      = third_used_q;
  assign clean_remaining = clean_q;
  assign clean_done      = clean_done_q;
  assign mode_changed    = mode_changed_q;

endmodule

// File: tb/tb_hood_mode_sequencer.sv
// Self-checking bench for hood_mode_sequencer: a vector table plus hand-written
// corner sequences, expected records queued at drive time and popped at sample time.
module tb_hood_mode_sequencer;

  localparam int CW = 16;

  localparam logic [5:0] N = 6'b000000;
  localparam logic [5:0] M = 6'b100000;
  localparam logic [5:0] F = 6'b010000;
  localparam logic [5:0] S = 6'b001000;
  localparam logic [5:0] T = 6'b000100;
  localparam logic [5:0] C = 6'b000010;
  localparam logic [5:0] G = 6'b000001;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          menu_signal = 1'b0, first_req = 1'b0, second_req = 1'b0;
  logic          third_req = 1'b0, clean_req = 1'b0, third_timeout_toggle = 1'b0;
  logic [2:0]    current_mode;
  logic          menu_active, third_used, clean_done, mode_changed;
  logic [CW-1:0] clean_remaining;

  always #5 clk = ~clk;

  hood_mode_sequencer #(
    .CNT_WIDTH(CW),
    .CLEAN_TIME(5),
    .MENU_TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .menu_signal(menu_signal),
    .first_req(first_req),
    .second_req(second_req),
    .third_req(third_req),
    .clean_req(clean_req),
    .third_timeout_toggle(third_timeout_toggle),
    .current_mode(current_mode),
    .menu_active(menu_active),
    .third_used(third_used),
    .clean_remaining(clean_remaining),
    .clean_done(clean_done),
    .mode_changed(mode_changed)
  );

  typedef struct {
    string      name;
    logic [5:0] in;
    logic [2:0] mode;
    logic       menu;
    logic       used;
    int         rem;
    logic       done;
    logic       chg;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[22];
  int   total = 0;
  int   bad = 0;

  function automatic vec_t mk(string name, logic [5:0] in, logic [2:0] mode, logic menu,
                              logic used, int rem, logic done, logic chg);
    vec_t v;
    v.name = name; v.in = in; v.mode = mode; v.menu = menu;
    v.used = used; v.rem = rem; v.done = done; v.chg = chg;
    return v;
  endfunction

  task automatic chk(string name, string field, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s: got %0d expected %0d", name, field, act, exp);
    end
  endtask

  task automatic compare_out();
    vec_t e;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard: empty queue");
      return;
    end
    e = exp_q.pop_front();
    chk(e.name, "mode", 32'(current_mode), 32'(e.mode));
    chk(e.name, "menu_active", 32'(menu_active), 32'(e.menu));
    chk(e.name, "third_used", 32'(third_used), 32'(e.used));
    chk(e.name, "clean_remaining", 32'(clean_remaining), 32'(e.rem));
    chk(e.name, "clean_done", 32'(clean_done), 32'(e.done));
    chk(e.name, "mode_changed", 32'(mode_changed), 32'(e.chg));
  endtask

  task automatic apply(vec_t v);
    @(negedge clk);
    {menu_signal, first_req, second_req, third_req, clean_req, third_timeout_toggle} = v.in;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic do_reset(string name);
    @(negedge clk);
    {menu_signal, first_req, second_req, third_req, clean_req, third_timeout_toggle} = N;
    rstn = 1'b0;
    #1;
    exp_q.push_back(mk(name, N, 3'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0));
    compare_out();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // name, inputs, mode, menu_active, third_used, clean_remaining, clean_done, mode_changed
    tbl[0]  = mk("idle_after_reset",  N, 3'd0, 0, 0, 0, 0, 0);
    tbl[1]  = mk("standby_ignore_s",  S, 3'd0, 0, 0, 0, 0, 0);
    tbl[2]  = mk("enter_menu",        M, 3'd0, 1, 0, 0, 0, 1);
    tbl[3]  = mk("menu_to_second",    S, 3'd2, 0, 0, 0, 0, 1);
    tbl[4]  = mk("second_hold",       N, 3'd2, 0, 0, 0, 0, 0);
    tbl[5]  = mk("second_ign_toggle", G, 3'd2, 0, 0, 0, 0, 0);
    tbl[6]  = mk("second_to_first",   F, 3'd1, 0, 0, 0, 0, 1);
    tbl[7]  = mk("first_ign_clean",   C, 3'd1, 0, 0, 0, 0, 0);
    tbl[8]  = mk("first_to_second",   S, 3'd2, 0, 0, 0, 0, 1);
    tbl[9]  = mk("second_to_standby", M, 3'd0, 0, 0, 0, 0, 1);
    tbl[10] = mk("menu_again",        M, 3'd0, 1, 0, 0, 0, 1);
    tbl[11] = mk("menu_to_third",     T, 3'd3, 0, 1, 0, 0, 1);
    tbl[12] = mk("third_ign_first",   F, 3'd3, 0, 1, 0, 0, 0);
    tbl[13] = mk("toggle_to_second",  G, 3'd2, 0, 1, 0, 0, 1);
    tbl[14] = mk("stale_toggle",      G, 3'd2, 0, 1, 0, 0, 0);
    tbl[15] = mk("second_third_used", T, 3'd2, 0, 1, 0, 0, 0);
    tbl[16] = mk("second_to_stby2",   M, 3'd0, 0, 1, 0, 0, 1);
    tbl[17] = mk("menu_third_used",   M, 3'd0, 1, 1, 0, 0, 1);
    tbl[18] = mk("menu_ign_third",    T, 3'd0, 1, 1, 0, 0, 0);
    tbl[19] = mk("menu_to_first",     F, 3'd1, 0, 1, 0, 0, 1);
    tbl[20] = mk("first_ign_third",   T, 3'd1, 0, 1, 0, 0, 0);
    tbl[21] = mk("first_to_standby",  M, 3'd0, 0, 1, 0, 0, 1);

    #12;
    exp_q.push_back(mk("reset_values", N, 3'd0, 0, 0, 0, 0, 0));
    compare_out();
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 22; i++) apply(tbl[i]);

    // Reset clears third_used, so THIRD is reachable again; menu beats the toggle.
    do_reset("reset_clears_used");
    apply(mk("mb_menu",          M,     3'd0, 1, 0, 0, 0, 1));
    apply(mk("mb_third",         T,     3'd3, 0, 1, 0, 0, 1));
    apply(mk("mb_menu_vs_tog",   M | G, 3'd0, 0, 1, 0, 0, 1));
    apply(mk("mb_stale_tog",     G,     3'd0, 0, 1, 0, 0, 0));

    // Clean run: five cycles in CLEAN, menu ignored, single done pulse.
    apply(mk("cl_menu",          M,     3'd0, 1, 1, 0, 0, 1));
    apply(mk("cl_enter",         C,     3'd4, 0, 1, 5, 0, 1));
    apply(mk("cl_rem4",          N,     3'd4, 0, 1, 4, 0, 0));
    apply(mk("cl_ign_menu",      M,     3'd4, 0, 1, 3, 0, 0));
    apply(mk("cl_rem2",          S,     3'd4, 0, 1, 2, 0, 0));
    apply(mk("cl_rem1",          N,     3'd4, 0, 1, 1, 0, 0));
    apply(mk("cl_done",          N,     3'd0, 0, 1, 0, 1, 1));
    apply(mk("cl_after",         N,     3'd0, 0, 1, 0, 0, 0));

    // Menu timeout: menu_active high for exactly four cycles.
    apply(mk("mt_enter",         M,     3'd0, 1, 1, 0, 0, 1));
    apply(mk("mt_c2",            N,     3'd0, 1, 1, 0, 0, 0));
    apply(mk("mt_c3",            N,     3'd0, 1, 1, 0, 0, 0));
    apply(mk("mt_c4",            N,     3'd0, 1, 1, 0, 0, 0));
    apply(mk("mt_expire",        N,     3'd0, 0, 1, 0, 0, 1));
    apply(mk("mt_stay",          N,     3'd0, 0, 1, 0, 0, 0));

    // Asynchronous reset in the middle of a clean run.
    apply(mk("ar_menu",          M,     3'd0, 1, 1, 0, 0, 1));
    apply(mk("ar_clean",         C,     3'd4, 0, 1, 5, 0, 1));
    apply(mk("ar_rem4",          N,     3'd4, 0, 1, 4, 0, 0));
    apply(mk("ar_rem3",          N,     3'd4, 0, 1, 3, 0, 0));
    #2;
    rstn = 1'b0;
    #1;
    exp_q.push_back(mk("ar_async", N, 3'd0, 0, 0, 0, 0, 0));
    compare_out();
    @(negedge clk);
    rstn = 1'b1;
    apply(mk("ar_post",          N,     3'd0, 0, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hood_mode_sequencer.md
# hood_mode_sequencer

Central mode state machine of the exhaust hood: it consumes user request pulses (menu and gear/clean buttons) and the level-type return toggle from the third-mode timeout controller, and produces the registered `current_mode` that the whole design, including the timeout controllers, decodes. It is the receiving end of the toggle interface. A toggle raised while in THIRD moves the hood to SECOND, after which the toggle source clears itself. The sequencer also enforces once-per-power-on third mode and runs the self-clean countdown.

## Interface
Parameters:
- `CNT_WIDTH`, 32: width of clean and menu counters.
- `CLEAN_TIME`, 100: cycles spent in CLEAN. The top level overrides it for real time. 0 is treated as 1.
- `MENU_TIMEOUT`, 50: maximum cycles in MENU without a valid request. 0 is treated as 1.
- Mode codes (3 bits): STANDBY=0, FIRST=1, SECOND=2, THIRD=3, CLEAN=4. MENU is reported as STANDBY plus `menu_active`.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `menu_signal` in 1: menu button, one-cycle pulse.
- `first_req`, `second_req`, `third_req`, `clean_req` in 1 each: gear/clean button pulses.
- `third_timeout_toggle` in 1: level from the third→second timeout controller. It is honoured only in THIRD.
- `current_mode` out 3: registered mode code.
- `menu_active` out 1: high while in MENU.
- `third_used` out 1: sticky; set on entry to THIRD.
- `clean_remaining` out CNT_WIDTH: CLEAN cycles left, including the current one. It is 0 outside CLEAN.
- `clean_done` out 1: one-cycle pulse when CLEAN completes.
- `mode_changed` out 1: one-cycle pulse in the first cycle of any new `current_mode`/`menu_active` combination.

## Operation
- States: STANDBY, MENU, FIRST, SECOND, THIRD, CLEAN. All transitions are evaluated on inputs sampled at a clock edge.
- **STANDBY**
  - `menu_signal` → MENU.
  - All other inputs are ignored.
- **MENU**
  - Priority: `menu_signal` → STANDBY (cancel).
  - Then `clean_req` → CLEAN.
  - Then `third_req` → THIRD, only if `third_used`=0. Otherwise the request is ignored and has no other effect in that cycle.
  - Then `second_req` → SECOND.
  - Then `first_req` → FIRST.
  - With no valid request, the menu counter increments. When the counter reaches MENU_TIMEOUT, the state becomes STANDBY.
  - The counter clears on MENU entry.
- **FIRST**
  - `menu_signal` → STANDBY (highest priority).
  - `second_req` → SECOND.
  - `third_req` → THIRD if `third_used`=0.
  - Other requests are ignored.
- **SECOND**
  - `menu_signal` → STANDBY.
  - `third_req` → THIRD if `third_used`=0.
  - `first_req` → FIRST.
- **THIRD**
  - `menu_signal` → STANDBY (highest priority).
  - `third_timeout_toggle`=1 → SECOND.
  - All other requests are ignored.
  - `third_used` is set in the same edge that enters THIRD.
  - `third_used` clears only on reset.
- **CLEAN**
  - All inputs are ignored, including `menu_signal`.
  - On entry, `clean_remaining` loads CLEAN_TIME.
  - Each CLEAN cycle: if `clean_remaining`=1, go to STANDBY with `clean_remaining`←0 and `clean_done`←1. Otherwise decrement.
- **Toggle input**
  - `third_timeout_toggle` is a level. The sequencer does not edge-detect it.
  - A stale high level after leaving THIRD is harmless, because it is ignored in every other state.
- **Reset**
  - Reset mid-CLEAN or mid-THIRD returns immediately to STANDBY.
  - Reset clears `third_used` and all counters.

## Timing
- Reset values:
  - `current_mode`=0 (STANDBY).
  - `menu_active`=0.
  - `third_used`=0.
  - `clean_remaining`=0.
  - `clean_done`=0.
  - `mode_changed`=0.
- Request latency:
  - A request sampled at edge N changes `current_mode`/`menu_active` in the cycle after edge N.
  - `mode_changed` is high in that same cycle only.
- THIRD return latency:
  - Toggle high at edge N → SECOND after edge N.
  - The toggle source then sees non-THIRD and drops its toggle one cycle later.
- CLEAN duration:
  - `current_mode`=CLEAN for exactly CLEAN_TIME cycles.
  - `clean_remaining` reads CLEAN_TIME, CLEAN_TIME-1, …, 1.
  - In the first STANDBY cycle, `clean_done`=1 and `mode_changed`=1.
- MENU duration: at most MENU_TIMEOUT cycles of `menu_active`=1 when no valid request arrives.
- Counter rules:
  - Counters never wrap.
  - The menu counter saturates at MENU_TIMEOUT.
  - The clean counter never decrements below 1 while in CLEAN.

## Test plan
- **Reset then menu, second:** reset, `menu_signal` pulse, then `second_req` pulse → `menu_active`=1 for one cycle, then `current_mode`=2 with a one-cycle `mode_changed`.
- **Third once only:** MENU, then `third_req` → mode 3 and `third_used`=1. Then `third_timeout_toggle`=1 for 2 cycles → mode 2 after the first edge. Then `third_req` in SECOND → stays at 2.
- **Menu in THIRD beats timeout:** in THIRD, `menu_signal` and `third_timeout_toggle` together → mode 0, `menu_active`=0.
- **Clean run (CLEAN_TIME=5):** MENU, then `clean_req` → mode 4 for exactly 5 cycles with `clean_remaining` 5..1. A `menu_signal` mid-run is ignored. `clean_done` pulses once with mode 0.
- **Menu timeout (MENU_TIMEOUT=4):** `menu_signal` with no further input → `menu_active` high for 4 cycles, then 0, mode stays 0.
- **Async reset mid-CLEAN:** assert `rstn`=0 at `clean_remaining`=3 → all outputs at reset values immediately, without waiting for a clock edge.
